johnson_phase_decoder: RTL and testbench

- Sits directly downstream of the 4-bit Johnson counter and takes its Count_out code as input.
- Checks the code sequence every Clock and decodes it to a phase index plus a one-hot phase vector.
- Counts completed Johnson cycles and flags illegal codes or illegal jumps with a sticky fault.
- Feeds phase-sequenced control logic, which uses only the registered, validated phase.

---
 rtl/johnson_phase_decoder_if.sv | 51 +++++
 rtl/johnson_phase_decoder.sv | 222 ++++++++++++++++++++++
 tb/tb_johnson_phase_decoder.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/johnson_phase_decoder_if.sv
// Bus bundle between the Johnson counter side and johnson_phase_decoder.
// The master modport is the upstream/consumer side. It drives Count_in and Clear.
// The slave modport is the decoder itself.
// Optional macro: JDEC_REVERSE_EN adds the Dir signal for reverse stepping.
interface johnson_phase_decoder_if #(
  parameter int WIDTH = 4,
  parameter int CYC_W = 8,
  parameter int IDX_W = 3
);

  logic [WIDTH-1:0]   Count_in;
  logic               Clear;
  logic [IDX_W-1:0]   Phase_idx;
  logic [2*WIDTH-1:0] Phase_onehot;
  logic               Locked;
  logic               Fault;
  logic               Wrap_pulse;
  logic [CYC_W-1:0]   Cycle_count;
`ifdef JDEC_REVERSE_EN
  logic               Dir;
`endif

  modport master (
    output Count_in,
    output Clear,
    input  Phase_idx,
    input  Phase_onehot,
    input  Locked,
    input  Fault,
    input  Wrap_pulse,
    input  Cycle_count
`ifdef JDEC_REVERSE_EN
    , input Dir
`endif
  );

  modport slave (
    input  Count_in,
    input  Clear,
    output Phase_idx,
    output Phase_onehot,
    output Locked,
    output Fault,
    output Wrap_pulse,
    output Cycle_count
`ifdef JDEC_REVERSE_EN
    , output Dir
`endif
  );

endinterface

// File: rtl/johnson_phase_decoder.sv
// Johnson phase decoder.
// The block checks the code stream from a WIDTH-bit Johnson counter.
// It decodes each code to a phase index and a one-hot phase vector.
// It counts completed Johnson cycles.
// It flags illegal codes or jumps with a sticky fault.
// All outputs are registered, so there is one cycle of latency from Count_in.
// Optional macro: JDEC_REVERSE_EN. When defined, predecessor steps are accepted.
// The macro also adds the Dir output.
module johnson_phase_decoder #(
  parameter int WIDTH = 4,
  parameter int CYC_W = 8,
  parameter int IDX_W = 3
) (
  input  logic Clock,
  input  logic Reset,
  johnson_phase_decoder_if.slave bus
);

  localparam int PHASES = 2 * WIDTH;
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(PHASES - 1);
  localparam logic [IDX_W-1:0]  IDX_ONE    = IDX_W'(1);
  localparam logic [CYC_W-1:0]  CYC_ONE    = CYC_W'(1);
  localparam logic [PHASES-1:0] ONEHOT_ONE = PHASES'(1);

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    LOCK  = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   phase_q, phase_d;
  logic [PHASES-1:0]  onehot_q, onehot_d;
  logic               locked_q, locked_d;
  logic               fault_q, fault_d;
  logic               wrap_q, wrap_d;
  logic [CYC_W-1:0]   cycleCount_q, cycleCount_d;
`ifdef JDEC_REVERSE_EN
  logic               dir_q, dir_d;
`endif

  logic               codeLegal;
  logic [IDX_W-1:0]   codeIdx;
  logic [IDX_W-1:0]   succIdx;
  logic               isHold;
  logic               isFwd;
`ifdef JDEC_REVERSE_EN
  logic [IDX_W-1:0]   predIdx;
  logic               isRev;
`endif

  // Legal Johnson code for phase k.
  // Phases 0..N fill ones from the bottom.
  // Phases N+1..2N-1 then clear ones from the bottom.
  function automatic logic [WIDTH-1:0] codeFor(input int k);
    logic [WIDTH-1:0] c;
    c = '0;
    for (int b = 0; b < WIDTH; b++) begin
      if (k <= WIDTH) begin
        c[b] = (b < k);
      end else begin
        c[b] = (b >= (k - WIDTH));
      end
    end
    return c;
  endfunction

  // Match the incoming code against every legal phase code.
  always_comb begin : decodeCode
    codeLegal = 1'b0;
    codeIdx   = '0;
    for (int k = 0; k < PHASES; k++) begin
      if (bus.Count_in == codeFor(k)) begin
        codeLegal = 1'b1;
        codeIdx   = IDX_W'(k);
      end
    end
  end

  // Classify the decoded code relative to the current locked phase.
  always_comb begin : classifyStep
    succIdx = (phase_q == LAST_IDX) ? '0 : (phase_q + IDX_ONE);
    isHold  = codeLegal && (codeIdx == phase_q);
    isFwd   = codeLegal && (codeIdx == succIdx);
`ifdef JDEC_REVERSE_EN
    predIdx = (phase_q == '0) ? LAST_IDX : (phase_q - IDX_ONE);
    isRev   = codeLegal && (codeIdx == predIdx);
`endif
  end

  // State register. Reset has top priority.
  always_ff @(posedge Clock) begin : stateReg
    if (!Reset) begin
      state_q <= HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Clear overrides sequence checking.
  always_comb begin : nextStateLogic
    state_d = state_q;
    if (bus.Clear) begin
      state_d = HUNT;
    end else begin
      unique case (state_q)
        HUNT: begin
          if (codeLegal) begin
            state_d = LOCK;
          end
        end
        LOCK: begin
`ifdef JDEC_REVERSE_EN
          if (!(isHold || isFwd || isRev)) begin
            state_d = FAULT;
          end
`else
          if (!(isHold || isFwd)) begin
            state_d = FAULT;
          end
`endif
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  // Next values of the registered outputs for the current state and code.
  always_comb begin : outputLogic
    phase_d      = phase_q;
    onehot_d     = onehot_q;
    locked_d     = locked_q;
    fault_d      = fault_q;
    wrap_d       = 1'b0;
    cycleCount_d = cycleCount_q;
`ifdef JDEC_REVERSE_EN
    dir_d        = dir_q;
`endif
    if (bus.Clear) begin
      phase_d      = '0;
      onehot_d     = '0;
      locked_d     = 1'b0;
      fault_d      = 1'b0;
      cycleCount_d = '0;
    end else begin
      unique case (state_q)
        HUNT: begin
          if (codeLegal) begin
            phase_d  = codeIdx;
            onehot_d = ONEHOT_ONE << codeIdx;
            locked_d = 1'b1;
          end
        end
        LOCK: begin
          if (isFwd) begin
            phase_d  = succIdx;
            onehot_d = ONEHOT_ONE << succIdx;
            if (phase_q == LAST_IDX) begin
              wrap_d       = 1'b1;
              cycleCount_d = cycleCount_q + CYC_ONE;
            end
`ifdef JDEC_REVERSE_EN
            dir_d = 1'b0;
          end else if (isRev) begin
            phase_d  = predIdx;
            onehot_d = ONEHOT_ONE << predIdx;
            if (phase_q == '0) begin
              wrap_d       = 1'b1;
              cycleCount_d = cycleCount_q - CYC_ONE;
            end
            dir_d = 1'b1;
`endif
          end else if (!isHold) begin
            fault_d  = 1'b1;
            locked_d = 1'b0;
          end
        end
        default: begin
          phase_d = phase_q;
        end
      endcase
    end
  end

  // Output registers. Reset clears everything.
  always_ff @(posedge Clock) begin : outputReg
    if (!Reset) begin
      phase_q      <= '0;
      onehot_q     <= '0;
      locked_q     <= 1'b0;
      fault_q      <= 1'b0;
      wrap_q       <= 1'b0;
      cycleCount_q <= '0;
`ifdef JDEC_REVERSE_EN
      dir_q        <= 1'b0;
`endif
    end else begin
      phase_q      <= phase_d;
      onehot_q     <= onehot_d;
      locked_q     <= locked_d;
      fault_q      <= fault_d;
      wrap_q       <= wrap_d;
      cycleCount_q <= cycleCount_d;
`ifdef JDEC_REVERSE_EN
      dir_q        <= dir_d;
`endif
    end
  end

  assign bus.Phase_idx    = phase_q;
  assign bus.Phase_onehot = onehot_q;
  assign bus.Locked       = locked_q;
  assign bus.Fault        = fault_q;
  assign bus.Wrap_pulse   = wrap_q;
  assign bus.Cycle_count  = cycleCount_q;
`ifdef JDEC_REVERSE_EN
  assign bus.Dir          = dir_q;
`endif

endmodule

// File: tb/tb_johnson_phase_decoder.sv
// Testbench for johnson_phase_decoder.
// It runs directed sequences and then random traffic.
// A phase-level reference model tracks the decoder.
// Optional macro: JDEC_REVERSE_EN enables the reverse-step checks and Dir.
module tb_johnson_phase_decoder;

  localparam int WIDTH  = 4;
  localparam int CYC_W  = 8;
  localparam int IDX_W  = 3;
  localparam int PHASES = 8;

  logic Clock;
  logic Reset;

  int checks;
  int failures;

  // Legal Johnson codes, listed by phase.
  logic [3:0] codes [PHASES] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111,
                                 4'b1111, 4'b1110, 4'b1100, 4'b1000};

  // Reference model state, kept as plain phase numbers and flags.
  int mPhase;
  int mCycles;
  bit mLocked;
  bit mFault;
  bit mWrap;
  bit mDir;

  johnson_phase_decoder_if #(.WIDTH(WIDTH), .CYC_W(CYC_W), .IDX_W(IDX_W)) intf ();

  johnson_phase_decoder #(.WIDTH(WIDTH), .CYC_W(CYC_W), .IDX_W(IDX_W)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (intf)
  );

  // Free-running clock.
  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // Phase of a legal code, or -1 for an illegal code.
  function automatic int codeIndex(input logic [3:0] c);
    int r;
    r = -1;
    for (int k = 0; k < PHASES; k++) begin
      if (codes[k] == c) r = k;
    end
    return r;
  endfunction

  // Apply one clock edge's worth of behaviour to the reference model.
  task automatic modelStep(input logic [3:0] code, input logic clr, input logic rstn);
    int k;
    k = codeIndex(code);
    mWrap = 1'b0;
    if (!rstn) begin
      mPhase = 0; mCycles = 0; mLocked = 0; mFault = 0; mDir = 0;
    end else if (clr) begin
      mPhase = 0; mCycles = 0; mLocked = 0; mFault = 0;
    end else if (mFault) begin
      mFault = 1'b1;
    end else if (!mLocked) begin
      if (k >= 0) begin
        mLocked = 1'b1;
        mPhase  = k;
      end
    end else if (k == mPhase) begin
      mLocked = 1'b1;
    end else if (k >= 0 && k == (mPhase + 1) % PHASES) begin
      if (mPhase == PHASES - 1) begin
        mWrap   = 1'b1;
        mCycles = (mCycles + 1) % (1 << CYC_W);
      end
      mPhase = k;
      mDir   = 1'b0;
`ifdef JDEC_REVERSE_EN
    end else if (k >= 0 && k == (mPhase + PHASES - 1) % PHASES) begin
      if (mPhase == 0) begin
        mWrap   = 1'b1;
        mCycles = (mCycles + (1 << CYC_W) - 1) % (1 << CYC_W);
      end
      mPhase = k;
      mDir   = 1'b1;
`endif
    end else begin
      mFault  = 1'b1;
      mLocked = 1'b0;
    end
  endtask

  // Single comparison point: counts and reports.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Compare every DUT output with the model.
  task automatic verifyAll();
    logic [31:0] expOnehot;
    expOnehot = (mLocked || mFault) ? (32'd1 << mPhase) : 32'd0;
    checkOutput("Phase_idx",    32'(intf.Phase_idx),    32'(mPhase));
    checkOutput("Phase_onehot", 32'(intf.Phase_onehot), expOnehot);
    checkOutput("Locked",       32'(intf.Locked),       32'(mLocked));
    checkOutput("Fault",        32'(intf.Fault),        32'(mFault));
    checkOutput("Wrap_pulse",   32'(intf.Wrap_pulse),   32'(mWrap));
    checkOutput("Cycle_count",  32'(intf.Cycle_count),  32'(mCycles));
`ifdef JDEC_REVERSE_EN
    checkOutput("Dir",          32'(intf.Dir),          32'(mDir));
`endif
  endtask

  // Drive inputs, clock once, update the model, then check 1 time unit after the edge.
  task automatic applyStimulus(input logic [3:0] code, input logic clr, input logic rstn);
    intf.Count_in = code;
    intf.Clear    = clr;
    Reset         = rstn;
    @(posedge Clock);
    modelStep(code, clr, rstn);
    #1;
    verifyAll();
  endtask

  task automatic driveIdx(input int k);
    applyStimulus(codes[k % PHASES], 1'b0, 1'b1);
  endtask

  initial begin
    int r;
    logic [3:0] c;
    checks   = 0;
    failures = 0;
    mPhase = 0; mCycles = 0; mLocked = 0; mFault = 0; mWrap = 0; mDir = 0;
    intf.Count_in = '0;
    intf.Clear    = 1'b0;
    Reset         = 1'b0;

    // Reset for two edges, then lock at phase 0.
    applyStimulus(4'b0000, 1'b0, 1'b0);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    applyStimulus(4'b0000, 1'b0, 1'b1);

    // Two full cycles of the sequence.
    for (int i = 1; i <= 16; i++) driveIdx(i);

    // Hold at phase 3, then advance to phase 4.
    for (int i = 1; i <= 3; i++) driveIdx(i);
    for (int i = 0; i < 5; i++) driveIdx(3);
    driveIdx(4);

    // A legal jump causes a fault. Garbage is ignored in fault. Clear, then relock.
    applyStimulus(4'b0000, 1'b1, 1'b1);
    driveIdx(2);
    applyStimulus(4'b1110, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(4'b0101, 1'b0, 1'b1);
    applyStimulus(4'b0101, 1'b1, 1'b1);
    applyStimulus(4'b1100, 1'b0, 1'b1);

    // A bad code in the same cycle as Clear goes to HUNT, not FAULT.
    applyStimulus(4'b1010, 1'b1, 1'b1);
    // Illegal codes while in HUNT.
    applyStimulus(4'b1010, 1'b0, 1'b1);
    applyStimulus(4'b0110, 1'b0, 1'b1);

    // Reset mid-sequence, together with Clear and an illegal code.
    driveIdx(4);
    driveIdx(5);
    applyStimulus(4'b0101, 1'b1, 1'b0);

`ifdef JDEC_REVERSE_EN
    // Reverse wrap from phase 0 to phase 7.
    applyStimulus(4'b0000, 1'b0, 1'b1);
    driveIdx(7);
    driveIdx(6);
    driveIdx(7);
`endif

    // Long forward run so Cycle_count wraps modulo 2^CYC_W.
    applyStimulus(4'b0000, 1'b1, 1'b1);
    applyStimulus(4'b0000, 1'b0, 1'b1);
    for (int i = 1; i <= 260 * PHASES; i++) driveIdx(i);

    // Random traffic biased toward legal stepping.
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        applyStimulus(4'($urandom), 1'($urandom), 1'b0);
      end else if (r < 5) begin
        applyStimulus(4'($urandom), 1'b1, 1'b1);
      end else begin
        if (r < 35)      c = codes[mPhase];
        else if (r < 85) c = codes[(mPhase + 1) % PHASES];
        else if (r < 92) c = codes[(mPhase + PHASES - 1) % PHASES];
        else             c = 4'($urandom);
        applyStimulus(c, 1'b0, 1'b1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
